// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter and its gate-tick source.
package freq_meter_pkg;

    // Defaults shared with the tick generator configuration.
    localparam int unsigned CNT_W_DEF        = 28;
    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned GATE_TIMEOUT_DEF = 110000000;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous input followed by a rising-edge pulse
// generator. Output pulse is one clk wide, STAGES+1 cycles after the input rises.
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser shift chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage captures its neighbour's old value, forming a real chain.
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gate-tick frequency meter: counts synchronised rising edges of sig_in between
// consecutive gate ticks and publishes the count (Hz for a 1 s gate).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned GATE_TIMEOUT = GATE_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             gate_tick,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic             gate_err,
    output logic             busy
);

    localparam int unsigned     WD_W    = $clog2(GATE_TIMEOUT + 1);
    // Watchdog value seen on the cycle whose edge completes GATE_TIMEOUT cycles.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(GATE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             freq_ovf_q, freq_ovf_d;
    logic             freq_valid_q, freq_valid_d;
    logic             gate_err_q, gate_err_d;
    logic             busy_q;

    logic             sig_rise;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;
    logic             timeout;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sig_in),
        .rise_o  (sig_rise)
    );

    // Saturating edge count including the current cycle's edge; an edge that
    // arrives while the counter is already all-ones is lost and flags overflow.
    assign cnt_full = &cnt_q;
    assign cnt_inc  = (sig_rise && !cnt_full) ? cnt_q + CNT_W'(1) : cnt_q;
    assign ovf_inc  = ovf_q | (sig_rise & cnt_full);
    assign timeout  = (wdog_q == WD_LAST);

    // Next-state logic: en has priority, then gate tick, then watchdog expiry.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        wdog_d       = wdog_q;
        freq_d       = freq_q;
        freq_ovf_d   = freq_ovf_q;
        freq_valid_d = 1'b0;
        gate_err_d   = gate_err_q;

        if (!en) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            wdog_d     = '0;
            gate_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    wdog_d  = '0;
                end
                ST_ARM: begin
                    if (gate_tick) begin
                        state_d = ST_COUNT;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        wdog_d  = '0;
                    end else if (timeout) begin
                        gate_err_d = 1'b1;
                        wdog_d     = '0;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (gate_tick) begin
                        // A coincident edge belongs to the window being closed.
                        freq_d       = cnt_inc;
                        freq_ovf_d   = ovf_inc;
                        freq_valid_d = 1'b1;
                        cnt_d        = '0;
                        ovf_d        = 1'b0;
                        wdog_d       = '0;
                    end else if (timeout) begin
                        gate_err_d = 1'b1;
                        state_d    = ST_ARM;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        wdog_d     = '0;
                    end else begin
                        cnt_d  = cnt_inc;
                        ovf_d  = ovf_inc;
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    wdog_d  = '0;
                end
            endcase
        end
    end

    // State, counters and published result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            wdog_q       <= '0;
            freq_q       <= '0;
            freq_ovf_q   <= 1'b0;
            freq_valid_q <= 1'b0;
            gate_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            wdog_q       <= wdog_d;
            freq_q       <= freq_d;
            freq_ovf_q   <= freq_ovf_d;
            freq_valid_q <= freq_valid_d;
            gate_err_q   <= gate_err_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign freq_ovf   = freq_ovf_q;
    assign gate_err   = gate_err_q;
    assign busy       = busy_q;

endmodule
